// File: rtl/shift_sequencer_if.sv
// Handshake bundle between the shift sequencer, its command source, its result
// consumer and the downstream 8-bit barrel shifter.
interface shift_sequencer_if #(
    parameter int AMT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic [AMT_W-1:0] in_amount;
    logic             in_dir;

    logic [7:0]       bs_data_in;
    logic [2:0]       bs_shift;
    logic             bs_left_right;
    logic [7:0]       bs_data_out;

    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             out_zero;

    // Environment side: command source, result consumer and the shifter itself.
    modport master (
        output in_valid, in_data, in_amount, in_dir, out_ready, bs_data_out,
        input  in_ready, out_valid, out_data, out_zero,
               bs_data_in, bs_shift, bs_left_right
    );

    // Sequencer side.
    modport slave (
        input  in_valid, in_data, in_amount, in_dir, out_ready, bs_data_out,
        output in_ready, out_valid, out_data, out_zero,
               bs_data_in, bs_shift, bs_left_right
    );
endinterface

// File: rtl/shift_sequencer.sv
// Splits a shift command into passes of at most 7 positions for the external
// barrel shifter, then holds the result until the consumer takes it.
module shift_sequencer #(
    parameter int AMT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_r;
    logic [7:0]       work_r;
    logic [AMT_W-1:0] remaining_r;
    logic             dir_r;

    logic [2:0]       pass_s;
    logic [AMT_W-1:0] rem_next_s;

    // Largest distance the shifter can take in one pass is 7.
    function automatic logic [2:0] pass_of(input logic [AMT_W-1:0] rem);
        logic [2:0] p;
        if (rem > AMT_W'(3'd7)) begin
            p = 3'd7;
        end else begin
            p = rem[2:0];
        end
        return p;
    endfunction

    // Distance of the current pass and what is left after it.
    always_comb begin
        pass_s     = pass_of(remaining_r);
        rem_next_s = remaining_r - AMT_W'(pass_s);
    end

    // Command/pass/result sequencing; an in-flight command is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            work_r      <= 8'h00;
            remaining_r <= '0;
            dir_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        work_r      <= bus.in_data;
                        remaining_r <= bus.in_amount;
                        dir_r       <= bus.in_dir;
                        state_r     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    work_r      <= bus.bs_data_out;
                    remaining_r <= rem_next_s;
                    if (rem_next_s == '0) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Everything below decodes registers only, so nothing from in_* reaches bs_*.
    assign bus.in_ready      = (state_r == ST_IDLE);
    assign bus.out_valid     = (state_r == ST_DONE);
    assign bus.out_data      = work_r;
    assign bus.out_zero      = (work_r == 8'h00);
    assign bus.bs_data_in    = work_r;
    assign bus.bs_shift      = (state_r == ST_SHIFT) ? pass_s : 3'd0;
    assign bus.bs_left_right = dir_r;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed and randomised bench for shift_sequencer with a behavioural 8-bit shifter.
module tb_shift_sequencer;

    localparam int AMT_W = 4;

    logic clk;
    logic rst_n;
    int   err_cnt;
    int   chk_cnt;

    logic [2:0] shifts_q[$];
    logic [7:0] works_q[$];

    shift_sequencer_if #(.AMT_W(AMT_W)) sif ();

    shift_sequencer #(.AMT_W(AMT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    // Downstream logical barrel shifter, zero fill on both sides.
    assign sif.bs_data_out = sif.bs_left_right ? (sif.bs_data_in >> sif.bs_shift)
                                               : (sif.bs_data_in << sif.bs_shift);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        chk_cnt++;
        if (obs !== exp_v) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] golden(input logic [7:0] d, input logic [3:0] a, input logic dr);
        logic [7:0] r;
        if (a >= 4'd8)  r = 8'h00;
        else if (dr)    r = d >> a;
        else            r = d << a;
        return r;
    endfunction

    // Issues one command and runs it to DONE, recording bs_shift and work per pass.
    task automatic run_cmd(input logic [7:0] d, input logic [3:0] a, input logic dr);
        int cyc;
        cyc = 0;
        while (!sif.in_ready && cyc < 40) begin
            step();
            cyc++;
        end
        check("ready_before_cmd", 32'(sif.in_ready), 32'd1);
        sif.in_valid  = 1'b1;
        sif.in_data   = d;
        sif.in_amount = a;
        sif.in_dir    = dr;
        step();
        sif.in_valid  = 1'b0;
        shifts_q.delete();
        works_q.delete();
        cyc = 0;
        while (!sif.out_valid && cyc < 40) begin
            shifts_q.push_back(sif.bs_shift);
            step();
            works_q.push_back(sif.out_data);
            cyc++;
        end
        check("done_timeout", 32'(sif.out_valid), 32'd1);
        check("ready_in_done", 32'(sif.in_ready), 32'd0);
    endtask

    task automatic take_result();
        sif.out_ready = 1'b1;
        step();
        sif.out_ready = 1'b0;
        check("idle_after_take", 32'(sif.in_ready), 32'd1);
        check("valid_after_take", 32'(sif.out_valid), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  32'(sif.in_ready),      32'd1);
        check({tag, "_out_valid"}, 32'(sif.out_valid),     32'd0);
        check({tag, "_out_data"},  32'(sif.out_data),      32'h00);
        check({tag, "_out_zero"},  32'(sif.out_zero),      32'd1);
        check({tag, "_bs_data"},   32'(sif.bs_data_in),    32'h00);
        check({tag, "_bs_shift"},  32'(sif.bs_shift),      32'd0);
        check({tag, "_bs_lr"},     32'(sif.bs_left_right), 32'd0);
    endtask

    initial begin
        logic [7:0] d;
        logic [3:0] a;
        logic       dr;
        int         dly;
        int         p_exp;

        err_cnt       = 0;
        chk_cnt       = 0;
        sif.in_valid  = 1'b0;
        sif.in_data   = 8'h00;
        sif.in_amount = 4'd0;
        sif.in_dir    = 1'b0;
        sif.out_ready = 1'b0;
        rst_n         = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("por");
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single pass: 0xB5 << 3 = 0xA8, result one cycle after accept.
        run_cmd(8'hB5, 4'd3, 1'b0);
        check("single_passes", 32'(shifts_q.size()), 32'd1);
        check("single_shift",  32'(shifts_q[0]),     32'd3);
        check("single_data",   32'(sif.out_data),    32'hA8);
        check("single_zero",   32'(sif.out_zero),    32'd0);
        take_result();

        // Amount 0 still takes exactly one pass of distance 0.
        run_cmd(8'h5A, 4'd0, 1'b1);
        check("zero_passes", 32'(shifts_q.size()), 32'd1);
        check("zero_shift",  32'(shifts_q[0]),     32'd0);
        check("zero_data",   32'(sif.out_data),    32'h5A);
        take_result();

        // 0x80 >> 9 as passes 7, 2 with work 0x01 then 0x00.
        run_cmd(8'h80, 4'd9, 1'b1);
        check("m9_passes", 32'(shifts_q.size()), 32'd2);
        check("m9_shift0", 32'(shifts_q[0]),     32'd7);
        check("m9_shift1", 32'(shifts_q[1]),     32'd2);
        check("m9_work0",  32'(works_q[0]),      32'h01);
        check("m9_work1",  32'(works_q[1]),      32'h00);
        check("m9_zero",   32'(sif.out_zero),    32'd1);
        take_result();

        // Amount 15 left runs passes 7, 7, 1.
        run_cmd(8'hFF, 4'd15, 1'b0);
        check("m15_passes", 32'(shifts_q.size()), 32'd3);
        check("m15_shift0", 32'(shifts_q[0]),     32'd7);
        check("m15_shift1", 32'(shifts_q[1]),     32'd7);
        check("m15_shift2", 32'(shifts_q[2]),     32'd1);
        check("m15_data",   32'(sif.out_data),    32'h00);
        take_result();

        // Backpressure: 0x3C << 2 = 0xF0 held while a new command waits.
        run_cmd(8'h3C, 4'd2, 1'b0);
        sif.in_valid  = 1'b1;
        sif.in_data   = 8'h81;
        sif.in_amount = 4'd1;
        sif.in_dir    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_data",  32'(sif.out_data),  32'hF0);
            check("bp_ready", 32'(sif.in_ready),  32'd0);
            check("bp_valid", 32'(sif.out_valid), 32'd1);
        end
        sif.out_ready = 1'b1;
        step();
        sif.out_ready = 1'b0;
        check("bp_idle", 32'(sif.in_ready), 32'd1);
        step();
        sif.in_valid = 1'b0;
        check("bp_new_data",  32'(sif.bs_data_in),    32'h81);
        check("bp_new_shift", 32'(sif.bs_shift),      32'd1);
        check("bp_new_dir",   32'(sif.bs_left_right), 32'd1);
        step();
        check("bp_new_valid", 32'(sif.out_valid), 32'd1);
        check("bp_new_res",   32'(sif.out_data),  32'h40);
        take_result();

        // Asynchronous reset in the middle of a 15-left command.
        sif.in_valid  = 1'b1;
        sif.in_data   = 8'hFF;
        sif.in_amount = 4'd15;
        sif.in_dir    = 1'b0;
        step();
        sif.in_valid = 1'b0;
        step();
        check("mid_shift_state", 32'(sif.bs_shift), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async");
        step();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_ready", 32'(sif.in_ready),  32'd1);
            check("post_rst_valid", 32'(sif.out_valid), 32'd0);
        end

        // Random commands against the golden full-distance model.
        for (int n = 0; n < 20; n++) begin
            d     = 8'($urandom_range(255));
            a     = 4'($urandom_range(15));
            dr    = 1'($urandom_range(1));
            dly   = int'($urandom_range(3));
            p_exp = (a == 4'd0) ? 1 : (int'(a) + 6) / 7;
            run_cmd(d, a, dr);
            check("rnd_passes", 32'(shifts_q.size()), 32'(p_exp));
            check("rnd_data",   32'(sif.out_data),    32'(golden(d, a, dr)));
            for (int i = 0; i < dly; i++) begin
                step();
                check("rnd_hold", 32'(sif.out_data), 32'(golden(d, a, dr)));
            end
            take_result();
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
